// File: rtl/lcd_bus_driver.sv
// HD44780 write-only bus driver: one byte per iStart rising edge. It generates the
// setup, enable-pulse and hold phases, then waits out the controller execution time.
module lcd_bus_driver #(
  parameter int T_SETUP      = 2,
  parameter int T_EN         = 16,
  parameter int T_HOLD       = 2,
  parameter int T_EXEC_SHORT = 2000,
  parameter int T_EXEC_LONG  = 82000,
  parameter int CNT_W        = 17
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] iDATA,
  input  logic       iRS,
  input  logic       iStart,
  output logic       oDone,
  output logic       oBusy,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  typedef enum logic [2:0] {IDLE, SETUP, EN_HI, HOLD, EXEC, DONE} state_t;

  state_t           state;
  logic             start_q;
  logic             long_q;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;

  assign cnt_last = (cnt == CNT_W'(1));
  assign LCD_RW   = 1'b0;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      long_q   <= 1'b0;
      cnt      <= '0;
      oDone    <= 1'b0;
      oBusy    <= 1'b0;
      LCD_DATA <= 8'h00;
      LCD_EN   <= 1'b0;
      LCD_RS   <= 1'b0;
    end else begin
      start_q <= iStart;
      oDone   <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart && !start_q) begin
            LCD_DATA <= iDATA;
            LCD_RS   <= iRS;
            // Clear display (0x01) and return home (0x02/0x03) need the long wait.
            long_q   <= !iRS && (iDATA[7:2] == 6'd0) && (iDATA[1:0] != 2'd0);
            oBusy    <= 1'b1;
            cnt      <= CNT_W'(T_SETUP);
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_last) begin
            LCD_EN <= 1'b1;
            cnt    <= CNT_W'(T_EN);
            state  <= EN_HI;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        EN_HI: begin
          if (cnt_last) begin
            LCD_EN <= 1'b0;
            cnt    <= CNT_W'(T_HOLD);
            state  <= HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt_last) begin
            cnt   <= long_q ? CNT_W'(T_EXEC_LONG) : CNT_W'(T_EXEC_SHORT);
            state <= EXEC;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        EXEC: begin
          if (cnt_last) begin
            oDone <= 1'b1;
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          oBusy <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Randomized scoreboard bench for lcd_bus_driver; a transfer-level model predicts
// launches, the enable window, busy span and the oDone edge of every transfer.
module tb_lcd_bus_driver;
  localparam int TS  = 2;
  localparam int TE  = 3;
  localparam int TH  = 2;
  localparam int TXS = 5;
  localparam int TXL = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = 8'h00;
  logic       rs = 1'b0;
  logic       start = 1'b0;
  logic       o_done, o_busy, lcd_rw, lcd_en, lcd_rs;
  logic [7:0] lcd_data;

  lcd_bus_driver #(
    .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH),
    .T_EXEC_SHORT(TXS), .T_EXEC_LONG(TXL), .CNT_W(17)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .iDATA(data), .iRS(rs), .iStart(start),
    .oDone(o_done), .oBusy(o_busy), .LCD_DATA(lcd_data), .LCD_RW(lcd_rw),
    .LCD_EN(lcd_en), .LCD_RS(lcd_rs)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned done_edge;
    logic [7:0]  data;
    logic        rs;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        popped;
  int          checks = 0;
  int          errors = 0;
  int unsigned edge_cnt = 0;
  int unsigned free_edge = 0;
  int unsigned cur_e0 = 0;
  int unsigned cur_tot = 0;
  bit          cur_valid = 1'b0;
  logic [7:0]  last_data = 8'h00;
  logic        last_rs = 1'b0;
  bit          prev_start = 1'b0;
  int          exp_dones = 0;
  int          dones_seen = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, edge_cnt);
    end
  endtask

  // Reference model: a transfer is a fixed-length occupation of the bus that starts
  // on an iStart rising edge seen while the driver is free.
  always @(posedge clk or negedge rst_n) begin : model
    int  tot;
    bit  lng;
    if (!rst_n) begin
      prev_start = 1'b0;
      cur_valid  = 1'b0;
      last_data  = 8'h00;
      last_rs    = 1'b0;
      free_edge  = edge_cnt + 1;
      exp_dones  = exp_dones - exp_q.size();
      exp_q.delete();
    end else begin
      edge_cnt++;
      if (start && !prev_start && edge_cnt >= free_edge) begin
        lng = (rs == 1'b0) && (data >= 8'd1) && (data <= 8'd3);
        tot = TS + TE + TH + (lng ? TXL : TXS);
        exp_q.push_back('{done_edge: edge_cnt + tot, data: data, rs: rs});
        exp_dones++;
        cur_valid = 1'b1;
        cur_e0    = edge_cnt;
        cur_tot   = tot;
        last_data = data;
        last_rs   = rs;
        free_edge = edge_cnt + tot + 2;
        $display("launch data=%02h rs=%0d at edge %0d, done due edge %0d", data, rs, edge_cnt, edge_cnt + tot);
      end
      prev_start = start;
    end
  end

  always @(negedge clk) begin : monitor
    bit exp_busy, exp_en;
    exp_busy = cur_valid && edge_cnt >= cur_e0 && edge_cnt <= cur_e0 + cur_tot;
    exp_en   = cur_valid && edge_cnt >= cur_e0 + TS && edge_cnt < cur_e0 + TS + TE;
    check("lcd_rw", lcd_rw, 0);
    check("busy", o_busy, exp_busy);
    check("lcd_en", lcd_en, exp_en);
    check("lcd_data", lcd_data, last_data);
    check("lcd_rs", lcd_rs, last_rs);
    if (o_done) begin
      dones_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got oDone=1 expected no pending transfer (edge %0d)", edge_cnt);
      end else begin
        popped = exp_q.pop_front();
        check("done_edge", edge_cnt, popped.done_edge);
        $display("done data=%02h rs=%0d at edge %0d", popped.data, popped.rs, edge_cnt);
      end
    end else if (exp_q.size() > 0 && exp_q[0].done_edge < edge_cnt) begin
      check("missed_done", o_done, 1);
      void'(exp_q.pop_front());
    end
  end

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_done && n < 300);
    if (!o_done) check("done_timeout", o_done, 1);
  endtask

  task automatic wait_en();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lcd_en && n < 50);
    if (!lcd_en) check("en_timeout", lcd_en, 1);
  endtask

  task automatic xfer(input logic [7:0] d, input logic r);
    int d0;
    @(negedge clk);
    data = d; rs = r; start = 1'b1;
    d0 = dones_seen;
    wait_done();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("xfer_count", dones_seen - d0, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int d0;
    int unsigned e_rel;
    repeat (3) @(negedge clk);
    check("rst_en", lcd_en, 0);
    check("rst_data", lcd_data, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    rst_n = 1'b1;

    xfer(8'h41, 1'b1);
    xfer(8'h01, 1'b0);
    xfer(8'h02, 1'b0);
    xfer(8'h06, 1'b0);

    // Host handshake: drop after oDone, re-raise three cycles later.
    @(negedge clk);
    d0 = dones_seen;
    data = 8'h30; rs = 1'b0; start = 1'b1;
    wait_done();
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    data = 8'h48; rs = 1'b1; start = 1'b1;
    wait_done();
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("handshake_count", dones_seen - d0, 2);

    // Request held high well past oDone must not relaunch.
    @(negedge clk);
    d0 = dones_seen;
    data = 8'h0C; rs = 1'b0; start = 1'b1;
    wait_done();
    repeat (30) @(negedge clk);
    check("held_count", dones_seen - d0, 1);
    start = 1'b0;

    // New request during the enable pulse is ignored.
    @(negedge clk);
    d0 = dones_seen;
    data = 8'h55; rs = 1'b1; start = 1'b1;
    wait_en();
    start = 1'b0;
    @(negedge clk);
    data = 8'hAA; start = 1'b1;
    wait_done();
    repeat (3) @(negedge clk);
    check("busy_start_count", dones_seen - d0, 1);
    check("busy_start_data", lcd_data, 8'h55);
    start = 1'b0;

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        rs = 1'b0; data = 8'($urandom_range(1, 3));
      end else begin
        rs = 1'($urandom); data = 8'($urandom);
      end
      start = 1'b1;
      repeat ($urandom_range(1, 35)) @(negedge clk);
      start = 1'b0;
      repeat ($urandom_range(1, 20)) @(negedge clk);
    end
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of the enable pulse.
    @(negedge clk);
    data = 8'h77; rs = 1'b1; start = 1'b1;
    wait_en();
    #2 rst_n = 1'b0;
    #1;
    check("async_en", lcd_en, 0);
    check("async_data", lcd_data, 0);
    check("async_rs", lcd_rs, 0);
    check("async_busy", o_busy, 0);
    @(negedge clk);
    data = 8'h21;
    repeat (2) @(negedge clk);
    d0 = dones_seen;
    e_rel = edge_cnt;
    rst_n = 1'b1;
    wait_done();
    check("release_latency", edge_cnt - e_rel, 1 + TS + TE + TH + TXS);
    repeat (3) @(negedge clk);
    check("release_count", dones_seen - d0, 1);
    start = 1'b0;

    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("total_dones", dones_seen, exp_dones);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
